// File: rtl/tick_divider.sv
// tick_divider: programmable clock-enable generator with pulse/toggle output
// and a wrapping tick counter; all outputs are registered.
module tick_divider #(
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 999_999,
    parameter int TCW         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode,
    output logic             tick,
    output logic             clk_out,
    output logic [WIDTH-1:0] div_cur,
    output logic [TCW-1:0]   tick_cnt
);
    logic [WIDTH-1:0] count;
    logic             term;

    assign term = count == div_cur;

    // Outside a terminal count, pulse mode forces clk_out low and toggle mode holds it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            div_cur  <= WIDTH'(DEFAULT_DIV);
            tick     <= 1'b0;
            clk_out  <= 1'b0;
            tick_cnt <= '0;
        end else if (clr) begin
            count    <= '0;
            tick     <= 1'b0;
            clk_out  <= 1'b0;
            tick_cnt <= '0;
        end else if (load) begin
            div_cur <= div_in;
            count   <= '0;
            tick    <= 1'b0;
            clk_out <= mode & clk_out;
        end else if (en) begin
            count    <= term ? '0 : count + 1'b1;
            tick     <= term;
            tick_cnt <= term ? tick_cnt + 1'b1 : tick_cnt;
            clk_out  <= term ? (mode ? ~clk_out : 1'b1) : (mode & clk_out);
        end else begin
            tick    <= 1'b0;
            clk_out <= mode & clk_out;
        end
    end
endmodule

// File: tb/tb_tick_divider.sv
// tb_tick_divider: scoreboard bench driven by a down-counting reference model
// plus directed checks of the documented timing cases.
module tb_tick_divider;
    localparam int W  = 8;
    localparam int DD = 3;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n, en, clr, load, mode;
    logic [W-1:0]  div_in;
    logic          tick, clk_out;
    logic [W-1:0]  div_cur;
    logic [TW-1:0] tick_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic          t;
        logic          c;
        logic [W-1:0]  d;
        logic [TW-1:0] n;
    } exp_t;
    exp_t q[$];

    int          m_rem, m_div;
    logic        m_tick, m_co;
    logic [TW-1:0] m_tc;

    tick_divider #(.WIDTH(W), .DEFAULT_DIV(DD), .TCW(TW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .div_in(div_in), .mode(mode), .tick(tick), .clk_out(clk_out),
        .div_cur(div_cur), .tick_cnt(tick_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model tracks cycles remaining until the terminal count.
    task automatic step();
        exp_t e;
        if (!rst_n) begin
            m_rem = DD; m_div = DD; m_tick = 0; m_co = 0; m_tc = '0;
        end else if (clr) begin
            m_rem = m_div; m_tick = 0; m_co = 0; m_tc = '0;
        end else if (load) begin
            m_div = int'(div_in); m_rem = m_div; m_tick = 0;
            if (!mode) m_co = 0;
        end else if (en) begin
            m_tick = (m_rem == 0);
            m_rem  = m_tick ? m_div : m_rem - 1;
            if (m_tick) begin
                m_tc = m_tc + 1'b1;
                m_co = mode ? ~m_co : 1'b1;
            end else if (!mode) m_co = 0;
        end else begin
            m_tick = 0;
            if (!mode) m_co = 0;
        end
        e = '{m_tick, m_co, W'(m_div), m_tc};
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("sb_tick", 32'(tick), 32'(e.t));
        chk("sb_clk_out", 32'(clk_out), 32'(e.c));
        chk("sb_div_cur", 32'(div_cur), 32'(e.d));
        chk("sb_tick_cnt", 32'(tick_cnt), 32'(e.n));
    endtask

    task automatic do_load(input logic [W-1:0] d);
        load = 1; div_in = d;
        step();
        load = 0;
    endtask

    initial begin
        rst_n = 0; en = 0; clr = 0; load = 0; mode = 0; div_in = '0;
        @(posedge clk); #1;
        step(); step();
        chk("rst_tick", 32'(tick), 0);
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_div_cur", 32'(div_cur), DD);
        chk("rst_tick_cnt", 32'(tick_cnt), 0);

        // default divisor 3: ticks on enabled edges 4, 8, 12
        rst_n = 1; en = 1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("t1_tick", 32'(tick), (i % 4 == 0) ? 1 : 0);
            chk("t1_clk_eq_tick", 32'(clk_out), 32'(tick));
            if (i % 4 == 0) chk("t1_tick_cnt", 32'(tick_cnt), i / 4);
        end

        // toggle mode, divisor 2
        clr = 1; step(); clr = 0;
        mode = 1; do_load(2);
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("t2_clk_out", 32'(clk_out), (i / 3) % 2);
            chk("t2_tick", 32'(tick), (i % 3 == 0) ? 1 : 0);
        end

        // reload to 1 at count 2
        mode = 0; do_load(3);
        step(); step();
        do_load(1);
        chk("t3_div_cur", 32'(div_cur), 1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("t3_tick", 32'(tick), (i % 2 == 0) ? 1 : 0);
        end

        // hold for 5 cycles at count 1
        do_load(3);
        step();
        en = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_tick", 32'(tick), 0);
        end
        en = 1;
        step(); chk("t4_resume1", 32'(tick), 0);
        step(); chk("t4_resume2", 32'(tick), 0);
        step(); chk("t4_resume3", 32'(tick), 1);

        // clr beats load; then reset restores default divisor
        step(); step();
        clr = 1; load = 1; div_in = 7;
        step();
        clr = 0; load = 0;
        chk("t5_div_kept", 32'(div_cur), 3);
        chk("t5_tick_cnt", 32'(tick_cnt), 0);
        chk("t5_clk_out", 32'(clk_out), 0);
        do_load(5);
        step(); step(); step();
        rst_n = 0; step(); rst_n = 1;
        chk("t5_rst_div", 32'(div_cur), DD);
        chk("t5_rst_cnt", 32'(tick_cnt), 0);
        chk("t5_rst_tick", 32'(tick), 0);

        // divisor 0 in toggle mode
        mode = 1; do_load(0);
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("t6_tick", 32'(tick), 1);
            chk("t6_tick_cnt", 32'(tick_cnt), i % 16);
            chk("t6_clk_out", 32'(clk_out), i % 2);
        end

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst_n  = ($urandom_range(0, 99) != 0);
            clr    = ($urandom_range(0, 39) == 0);
            load   = ($urandom_range(0, 19) == 0);
            en     = ($urandom_range(0, 3) != 0);
            mode   = ($urandom_range(0, 29) == 0) ? ~mode : mode;
            div_in = W'($urandom_range(0, 5));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
